div_32bit_seq: RTL and testbench
================================

Name: div_32bit_seq

Overview:
- Multi-cycle 32-bit integer divider for MiniMIPS DIV/DIVU. It is the inverse operation to the multiply path.
- Radix-2 restoring algorithm, one quotient bit per clock, with a start/busy/done handshake.
- Sits beside the ALU and feeds the HI/LO registers: quotient goes to LO, remainder goes to HI.
- Signed operation uses two's-complement negation (bitwise invert, then +1) on entry and on exit.

Parameters:
- WIDTH, 32, operand/result width. Only 32 is verified.
- CNT_W, 5, iteration-counter width, equal to log2(WIDTH).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a division; sampled only when busy=0
- is_signed  input  1  1=DIV (signed), 0=DIVU; sampled with start
- dividend  input  WIDTH  numerator; sampled with start
- divisor  input  WIDTH  denominator; sampled with start
- busy  output  1  operation in progress; start is ignored while high
- done  output  1  one-cycle pulse; results valid from this cycle
- quotient  output  WIDTH  registered quotient (to LO)
- remainder  output  WIDTH  registered remainder (to HI)
- div_by_zero  output  1  registered flag: latched divisor was 0

Behaviour:
- Reset (rst_n low, asynchronous, any state):
  - state=IDLE; busy, done, div_by_zero, quotient, remainder, counter and internal registers all 0.
  - An operation in flight is discarded. No done pulse appears after reset is released.
- States: IDLE, RUN, FIX, DONE.
- IDLE/DONE, start=1 at edge E0:
  - Latch is_signed, sign bits, |dividend|, |divisor|. Magnitudes are taken only when is_signed=1 and the operand MSB is 1.
  - Clear partial remainder P (WIDTH+1 bits) and counter. Go to RUN.
- IDLE/DONE, start=0: DONE goes to IDLE; IDLE stays IDLE.
- RUN, one edge per iteration, WIDTH edges total:
  - Shift {P,Q} left by one.
  - T = P - {0,|divisor|} (WIDTH+1-bit subtract).
  - If T MSB=0: P=T, Q[0]=1. Otherwise keep P, Q[0]=0.
  - Counter increments; at counter=WIDTH-1 go to FIX.
- FIX, one edge:
  - If divisor==0: quotient=all ones, remainder=original dividend, div_by_zero=1. No sign fix-up.
  - Otherwise: quotient=Q, negated if is_signed and the operand signs differ. Remainder=P[WIDTH-1:0], negated if is_signed and the dividend was negative. div_by_zero=0.
  - Go to DONE.
- DONE: done=1 for exactly one cycle; busy=0.
- Timing:
  - Start sampled high in cycle 0. busy=1 in cycles 1..33. done=1 in cycle 34.
  - Fixed latency of 34 cycles, including divide-by-zero.
- quotient, remainder and div_by_zero hold until the FIX edge of the next operation. They do not change when start is accepted.
- start while busy=1 is ignored and has no side effects. Operand changes while busy have no effect.
- start in the DONE cycle is accepted (back-to-back). done still pulses that cycle, and the next done comes 34 cycles later.
- Signed overflow, 0x80000000 / 0xFFFFFFFF signed: quotient=0x80000000, remainder=0, div_by_zero=0. This falls out of the unsigned magnitude path and needs no special case.
- Remainder sign always follows the dividend (truncating division). Remainder is 0 or has magnitude less than |divisor|.

Decomposition:
- Shared package (div_pkg):
  - WIDTH and CNT_W constants.
  - State encoding localparams: IDLE=2'd0, RUN=2'd1, FIX=2'd2, DONE=2'd3.
  - Divide-by-zero quotient constant, all ones.
- One natural sub-module: neg_32bit, a combinational two's-complement negate (bitwise invert, then +1 ripple increment).
  - Two instances: operand magnitude on entry; result/remainder fix-up in FIX (muxed).
- The WIDTH+1-bit trial subtractor lives inline in div_32bit_seq.

Test Plan:
- Unsigned 100/7:
  - start at cycle 0 -> busy 1 in cycles 1-33.
  - done in cycle 34 only, with quotient=14, remainder=2, div_by_zero=0.
- Signed cases:
  - -100/7 -> quotient=0xFFFFFFF2, remainder=0xFFFFFFFE.
  - 100/-7 -> quotient=0xFFFFFFF2, remainder=2.
- Divide by zero: 0x00001234/0, signed and unsigned -> quotient=0xFFFFFFFF, remainder=0x00001234, div_by_zero=1, done at cycle 34.
- Edge operands:
  - 0x80000000 / 0xFFFFFFFF signed -> quotient=0x80000000, remainder=0.
  - Same operands unsigned -> quotient=0, remainder=0x80000000.
- Handshake:
  - start=1 held high with new operands during cycles 5-20 -> ignored; first result unchanged.
  - start in the DONE cycle with 9/2 -> new done 34 cycles later, quotient=4, remainder=1.
- Reset mid-operation: rst_n low in cycle 10 -> busy, done and outputs 0 immediately with no clock edge. After release, no done appears; a fresh 100/7 yields 14/2 at latency 34.

Source files
------------

// File: rtl/div_32bit_seq_pkg.sv
// Shared constants for the sequential MiniMIPS divider: datapath width, FSM encoding,
// and the quotient value reported for a zero divisor.
package div_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = 5;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [WIDTH-1:0] DZ_QUO = '1;

endpackage

// File: rtl/div_32bit_seq_neg.sv
// Two's-complement negate (invert, then +1 ripple increment); purely combinational.
// Zero latency, no flow control.
module neg_32bit #(
  parameter int WIDTH = div_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);

  logic carry;

  always_comb begin
    carry = 1'b1;
    y     = '0;
    for (int i = 0; i < WIDTH; i++) begin
      y[i]  = ~a[i] ^ carry;
      carry = carry & ~a[i];
    end
  end

endmodule

// File: rtl/div_32bit_seq.sv
// Radix-2 restoring divider for DIV/DIVU: quotient to LO, remainder to HI.
// Fixed 34-cycle start-to-done latency; start is ignored while busy, accepted again in the done cycle.
module div_32bit_seq #(
  parameter int WIDTH = div_pkg::WIDTH,
  parameter int CNT_W = div_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  import div_pkg::*;

  logic [1:0]       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sgn_q;
  logic             neg_n_q;
  logic             neg_d_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dsr_q;
  logic [WIDTH-1:0] p_q;
  logic [WIDTH-1:0] q_q;

  logic             accept;
  logic             n_neg;
  logic             d_neg;
  logic [WIDTH-1:0] neg_a_in, neg_a_out;
  logic [WIDTH-1:0] neg_b_in, neg_b_out;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;

  assign accept = start && (state_q == IDLE || state_q == DONE);
  assign n_neg  = is_signed & dividend[WIDTH-1];
  assign d_neg  = is_signed & divisor[WIDTH-1];

  // Both negators are shared: operand magnitudes on entry, result fix-up in FIX.
  assign neg_a_in = (state_q == FIX) ? q_q : dividend;
  assign neg_b_in = (state_q == FIX) ? p_q : divisor;

  neg_32bit #(.WIDTH(WIDTH)) u_neg_a (.a(neg_a_in), .y(neg_a_out));
  neg_32bit #(.WIDTH(WIDTH)) u_neg_b (.a(neg_b_in), .y(neg_b_out));

  // P is stored WIDTH wide; the shifted value is WIDTH+1 wide for the trial subtract.
  assign rem_sh = {p_q, q_q[WIDTH-1]};
  assign trial  = rem_sh - {1'b0, dsr_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sgn_q       <= 1'b0;
      neg_n_q     <= 1'b0;
      neg_d_q     <= 1'b0;
      dvd_q       <= '0;
      dsr_q       <= '0;
      p_q         <= '0;
      q_q         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            sgn_q   <= is_signed;
            neg_n_q <= n_neg;
            neg_d_q <= d_neg;
            dvd_q   <= dividend;
            dsr_q   <= d_neg ? neg_b_out : divisor;
            q_q     <= n_neg ? neg_a_out : dividend;
            p_q     <= '0;
            cnt_q   <= '0;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          if (!trial[WIDTH]) begin
            p_q <= trial[WIDTH-1:0];
            q_q <= {q_q[WIDTH-2:0], 1'b1};
          end else begin
            p_q <= rem_sh[WIDTH-1:0];
            q_q <= {q_q[WIDTH-2:0], 1'b0};
          end
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) state_q <= FIX;
        end
        FIX: begin
          if (dsr_q == '0) begin
            quotient    <= DZ_QUO;
            remainder   <= dvd_q;
            div_by_zero <= 1'b1;
          end else begin
            quotient    <= (sgn_q && (neg_n_q ^ neg_d_q)) ? neg_a_out : q_q;
            remainder   <= (sgn_q && neg_n_q) ? neg_b_out : p_q;
            div_by_zero <= 1'b0;
          end
          state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = (state_q == RUN) || (state_q == FIX);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_div_32bit_seq.sv
// Scoreboard bench for div_32bit_seq: directed operands with hand-computed results,
// plus handshake timing, start-while-busy, back-to-back and mid-operation reset.
module tb_div_32bit_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_r[$];
  logic        exp_z[$];
  logic [31:0] prev_q = 32'h0;

  div_32bit_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expected result.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 required=0");
      end else begin
        chk("quotient", quotient, exp_q.pop_front());
        chk("remainder", remainder, exp_r.pop_front());
        chk("div_by_zero", {31'b0, div_by_zero}, {31'b0, exp_z.pop_front()});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered 1 time unit after a rising edge (cycle 0); returns in the done cycle.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [31:0] eq, input logic [31:0] er, input logic ez,
                        input logic spam);
    int lat = 0;
    int bcnt = 0;
    start = 1'b1; is_signed = s; dividend = a; divisor = b;
    exp_q.push_back(eq); exp_r.push_back(er); exp_z.push_back(ez);
    for (int k = 1; k <= 40; k++) begin
      step();
      if (spam && k >= 5 && k <= 20) begin
        start = 1'b1; is_signed = 1'b1; dividend = 32'h0000DEAD; divisor = 32'h3;
      end else begin
        start = 1'b0;
      end
      if (k == 1) chk("quotient_hold_on_start", quotient, prev_q);
      if (busy) bcnt++;
      if (done) begin
        lat = k;
        break;
      end
    end
    chk("done_latency", lat, 34);
    chk("busy_cycles", bcnt, 33);
    prev_q = eq;
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_busy"}, {31'b0, busy}, 32'h0);
    chk({tag, "_done"}, {31'b0, done}, 32'h0);
    chk({tag, "_quotient"}, quotient, 32'h0);
    chk({tag, "_remainder"}, remainder, 32'h0);
    chk({tag, "_dbz"}, {31'b0, div_by_zero}, 32'h0);
  endtask

  task automatic quiet(input int n, input string name);
    int seen = 0;
    for (int k = 0; k < n; k++) begin
      step();
      if (done) seen++;
    end
    chk(name, seen, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    repeat (3) step();
    chk_cleared("reset");
    rst_n = 1'b1;
    step();

    run_op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 1'b0);
    step();
    run_op(32'hFFFFFF9C, 32'd7, 1'b1, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 1'b0);
    step();
    run_op(32'd100, 32'hFFFFFFF9, 1'b1, 32'hFFFFFFF2, 32'd2, 1'b0, 1'b0);
    step();
    run_op(32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1, 32'd14, 32'hFFFFFFFE, 1'b0, 1'b0);
    step();
    run_op(32'h00001234, 32'h0, 1'b1, 32'hFFFFFFFF, 32'h00001234, 1'b1, 1'b0);
    step();
    run_op(32'h00001234, 32'h0, 1'b0, 32'hFFFFFFFF, 32'h00001234, 1'b1, 1'b0);
    step();
    run_op(32'hFFFFFFFB, 32'h0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1, 1'b0);
    step();
    run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'h0, 1'b0, 1'b0);
    step();
    run_op(32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h0, 32'h80000000, 1'b0, 1'b0);
    step();
    run_op(32'hFFFFFFFF, 32'd1, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0);
    step();
    run_op(32'd7, 32'd100, 1'b0, 32'h0, 32'd7, 1'b0, 1'b0);
    step();

    // start held with fresh operands mid-operation must not disturb it or queue another
    run_op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 1'b1);
    quiet(40, "no_done_after_ignored_start");

    // back-to-back: second start issued in the first op's done cycle
    run_op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 1'b0);
    run_op(32'd9, 32'd2, 1'b0, 32'd4, 32'd1, 1'b0, 1'b0);
    step();
    run_op(32'h00001234, 32'h0, 1'b0, 32'hFFFFFFFF, 32'h00001234, 1'b1, 1'b0);
    step();

    // mid-operation asynchronous reset
    start = 1'b1; is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
    step();
    start = 1'b0;
    repeat (9) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk_cleared("async_reset");
    step();
    rst_n = 1'b1;
    prev_q = 32'h0;
    quiet(40, "no_done_after_reset");
    run_op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 1'b0);
    step();

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
